membus_ram_responder: RTL and testbench



---
 rtl/membus_ram_pkg.sv | 13 +
 rtl/membus_ram_array.sv | 29 ++
 rtl/membus_ram_responder.sv | 142 ++++++++++++++
 tb/tb_membus_ram_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/membus_ram_pkg.sv
// Shared types and constants for the membus RAM responder.
package membus_ram_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} membus_ram_state_e;

  localparam int unsigned MEMBUS_RAM_MAX_LATENCY = 15;

  // Byte-offset bits within one bus word.
  function automatic int unsigned membus_ram_align(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/membus_ram_array.sv
// Single-port RAM: synchronous byte-masked write, combinational read.
module membus_ram_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (wmask[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/membus_ram_responder.sv
// membus slave backed by a byte-maskable RAM with fixed response latency.
// Optional MEMBUS_RAM_RANGE_CHECK_EN adds an err output and suppresses out-of-range accesses.
module membus_ram_responder
  import membus_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  output logic                    ready,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    wen,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
  output logic                    err,
`endif
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned ALIGN = membus_ram_align(DATA_WIDTH);
  localparam int unsigned TOP   = ALIGN + DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;

  if (LATENCY < 1 || LATENCY > MEMBUS_RAM_MAX_LATENCY) begin : g_bad_latency
    $error("membus_ram_responder: LATENCY out of range");
  end

  membus_ram_state_e     state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] resp_q;

  logic                  accept_c;
  logic                  oor_c;
  logic                  we_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic [DATA_WIDTH-1:0] ram_rdata_c;
  logic [DATA_WIDTH-1:0] cap_c;

  assign accept_c = valid & ready;
  assign idx_c    = addr[TOP-1:ALIGN];

`ifdef MEMBUS_RAM_RANGE_CHECK_EN
  logic err_q;
  assign oor_c = |addr[ADDR_WIDTH-1:TOP];
`else
  assign oor_c = 1'b0;
  logic unused_addr_c;
  assign unused_addr_c = ^addr[ADDR_WIDTH-1:TOP];
`endif

  if (ALIGN > 0) begin : g_low_bits
    logic unused_low_c;
    assign unused_low_c = ^addr[ALIGN-1:0];
  end

  assign we_c  = accept_c & wen & ~oor_c;
  // Writes and out-of-range reads both answer with zero data.
  assign cap_c = (wen | oor_c) ? '0 : ram_rdata_c;

  membus_ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (we_c),
    .idx  (idx_c),
    .wdata(wdata),
    .wmask(wmask),
    .rdata(ram_rdata_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ready  <= 1'b1;
      rvalid <= 1'b0;
      rdata  <= '0;
      resp_q <= '0;
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
      err    <= 1'b0;
      err_q  <= 1'b0;
`endif
    end else begin
      rvalid <= 1'b0;
      rdata  <= '0;
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
      err    <= 1'b0;
`endif
      case (state)
        IDLE, RESP: begin
          if (accept_c) begin
            resp_q <= cap_c;
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
            err_q  <= oor_c;
`endif
            if (LATENCY == 1) begin
              state  <= RESP;
              ready  <= 1'b1;
              rvalid <= 1'b1;
              rdata  <= cap_c;
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
              err    <= oor_c;
`endif
            end else begin
              state <= WAIT;
              ready <= 1'b0;
              cnt   <= CNT_W'(LATENCY - 2);
            end
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state  <= RESP;
            ready  <= 1'b1;
            rvalid <= 1'b1;
            rdata  <= resp_q;
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
            err    <= err_q;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_membus_ram_responder.sv
// Directed bench: LATENCY=1 instance driven from a vector table, LATENCY=3 instance by hand sequences.
module tb_membus_ram_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY = 1 instance
  logic        rst1, valid1, ready1, wen1, rvalid1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0]  wmask1;
  // LATENCY = 3 instance
  logic        rst3, valid3, ready3, wen3, rvalid3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  wmask3;
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
  logic        err1, err3;
`endif

  membus_ram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(12), .LATENCY(1)) d1 (
    .clk(clk), .rst(rst1), .valid(valid1), .ready(ready1), .addr(addr1), .wen(wen1),
    .wdata(wdata1), .wmask(wmask1),
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
    .err(err1),
`endif
    .rvalid(rvalid1), .rdata(rdata1));

  membus_ram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(12), .LATENCY(3)) d3 (
    .clk(clk), .rst(rst3), .valid(valid3), .ready(ready3), .addr(addr3), .wen(wen3),
    .wdata(wdata3), .wmask(wmask3),
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
    .err(err3),
`endif
    .rvalid(rvalid3), .rdata(rdata3));

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  vec_t vecs[12];

  initial begin
    rst1 = 1; valid1 = 0; addr1 = 0; wen1 = 0; wdata1 = 0; wmask1 = 0;
    rst3 = 1; valid3 = 0; addr3 = 0; wen3 = 0; wdata3 = 0; wmask3 = 0;

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h14,   32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 32'h14,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h14,   32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
    vecs[7]  = '{1'b0, 32'h13,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[8]  = '{1'b1, 32'h0,    32'h01020304, 4'hF, 32'h0,        1'b0};
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
    vecs[9]  = '{1'b1, 32'h4000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h01020304, 1'b0};
    vecs[11] = '{1'b0, 32'h4000, 32'h0,        4'h0, 32'h0,        1'b1};
`else
    vecs[9]  = '{1'b1, 32'h4000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b0, 32'h4000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
`endif

    repeat (2) @(negedge clk);
    rst1 = 0; rst3 = 0;
    @(negedge clk);
    chk("reset ready1", 32'(ready1), 32'h1);
    chk("reset rvalid1", 32'(rvalid1), 32'h0);
    chk("reset rdata1", rdata1, 32'h0);
    chk("reset ready3", 32'(ready3), 32'h1);
    chk("reset rvalid3", 32'(rvalid3), 32'h0);
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
    chk("reset err1", 32'(err1), 32'h0);
`endif

    // Single transactions on the LATENCY=1 instance
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d idle rvalid", i), 32'(rvalid1), 32'h0);
      chk($sformatf("vec%0d ready", i), 32'(ready1), 32'h1);
      valid1 = 1; wen1 = vecs[i].wen; addr1 = vecs[i].addr;
      wdata1 = vecs[i].wdata; wmask1 = vecs[i].wmask;
      @(negedge clk);
      valid1 = 0;
      chk($sformatf("vec%0d rvalid", i), 32'(rvalid1), 32'h1);
      chk($sformatf("vec%0d rdata", i), rdata1, vecs[i].exp_rdata);
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
      chk($sformatf("vec%0d err", i), 32'(err1), 32'(vecs[i].exp_err));
`endif
    end

    // Back-to-back writes then reads, valid held high
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i <= 8; i++) begin
        @(negedge clk);
        if (i > 0) begin
          chk($sformatf("b2b p%0d rvalid%0d", pass, i - 1), 32'(rvalid1), 32'h1);
          chk($sformatf("b2b p%0d rdata%0d", pass, i - 1), rdata1,
              (pass == 0) ? 32'h0 : 32'h1000_0000 + 32'(i - 1));
        end
        if (i < 8) begin
          chk($sformatf("b2b p%0d ready%0d", pass, i), 32'(ready1), 32'h1);
          valid1 = 1; wen1 = (pass == 0); addr1 = 32'(i * 4);
          wdata1 = 32'h1000_0000 + 32'(i); wmask1 = 4'hF;
        end else begin
          valid1 = 0;
        end
      end
      @(negedge clk);
      chk($sformatf("b2b p%0d tail rvalid", pass), 32'(rvalid1), 32'h0);
    end

    // LATENCY=3: write, then fields changed after accept must not matter
    @(negedge clk);
    valid3 = 1; wen3 = 1; addr3 = 32'h20; wdata3 = 32'h55AA00FF; wmask3 = 4'hF;
    @(negedge clk);
    valid3 = 0; addr3 = 32'h20; wdata3 = 32'h0BADBAD0;
    chk("l3w t1 ready", 32'(ready3), 32'h0);
    chk("l3w t1 rvalid", 32'(rvalid3), 32'h0);
    @(negedge clk);
    chk("l3w t2 ready", 32'(ready3), 32'h0);
    chk("l3w t2 rvalid", 32'(rvalid3), 32'h0);
    @(negedge clk);
    chk("l3w t3 rvalid", 32'(rvalid3), 32'h1);
    chk("l3w t3 rdata", rdata3, 32'h0);
    chk("l3w t3 ready", 32'(ready3), 32'h1);

    // LATENCY=3: read with a second request held through WAIT, accepted at t+3
    @(negedge clk);
    valid3 = 1; wen3 = 0; addr3 = 32'h20;
    @(negedge clk);
    wen3 = 1; addr3 = 32'h24; wdata3 = 32'h00000077; wmask3 = 4'hF;
    chk("l3r t1 ready", 32'(ready3), 32'h0);
    @(negedge clk);
    chk("l3r t2 ready", 32'(ready3), 32'h0);
    chk("l3r t2 rvalid", 32'(rvalid3), 32'h0);
    @(negedge clk);
    chk("l3r t3 rvalid", 32'(rvalid3), 32'h1);
    chk("l3r t3 rdata", rdata3, 32'h55AA00FF);
    chk("l3r t3 ready", 32'(ready3), 32'h1);
    @(negedge clk);
    valid3 = 0;
    chk("l3w2 t1 ready", 32'(ready3), 32'h0);
    chk("l3w2 t1 rvalid", 32'(rvalid3), 32'h0);
    @(negedge clk);
    chk("l3w2 t2 rvalid", 32'(rvalid3), 32'h0);
    @(negedge clk);
    chk("l3w2 t3 rvalid", 32'(rvalid3), 32'h1);
    chk("l3w2 t3 rdata", rdata3, 32'h0);
    @(negedge clk);
    valid3 = 1; wen3 = 0; addr3 = 32'h24;
    @(negedge clk);
    valid3 = 0;
    repeat (2) @(negedge clk);
    chk("l3r2 rvalid", 32'(rvalid3), 32'h1);
    chk("l3r2 rdata", rdata3, 32'h00000077);

    // LATENCY=3: reset while WAITing discards the response
    @(negedge clk);
    valid3 = 1; wen3 = 0; addr3 = 32'h20;
    @(negedge clk);
    valid3 = 0; rst3 = 1;
    @(negedge clk);
    rst3 = 0;
    chk("rst ready", 32'(ready3), 32'h1);
    chk("rst rvalid", 32'(rvalid3), 32'h0);
    chk("rst state", 32'(d3.state), 32'h0);
    @(negedge clk);
    chk("rst t3 rvalid", 32'(rvalid3), 32'h0);
    chk("rst t3 ready", 32'(ready3), 32'h1);
    @(negedge clk);
    chk("rst t4 rvalid", 32'(rvalid3), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
